// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU output path: frame geometry, control-word
// type encodings, error flag positions and serializer word builders.
package mtm_alu_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_WORDS = 5;
  localparam int CTL_WORDS  = 1;

  // Bit 7 of the serializer word tells the serializer which frame length to send.
  typedef enum logic {
    CTL_DATA  = 1'b0,
    CTL_ERROR = 1'b1
  } ctl_type_e;

  localparam int ERR_DATA_BIT = 5;
  localparam int ERR_CRC_BIT  = 4;
  localparam int ERR_OP_BIT   = 3;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } sched_state_e;

  function automatic logic [39:0] result_word(input logic [31:0] c, input logic [3:0] flags);
    return {c, 1'(CTL_DATA), flags, 3'b000};
  endfunction

  function automatic logic [39:0] error_word(input logic [5:0] flags);
    return {32'h0, 1'(CTL_ERROR), flags, 1'b0};
  endfunction

endpackage

// File: rtl/mtm_alu_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; pushes when full and
// pops when empty are ignored.
module mtm_alu_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + CW'(1);
    else if (!push_ok && pop_ok)
      count_next = count - CW'(1);
  end

  // Storage carries no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/mtm_alu_out_scheduler.sv
// Buffers ALU results and error responses and paces one-cycle loads into the
// handshake-less output serializer so an in-flight frame is never overwritten.
module mtm_alu_out_scheduler
  import mtm_alu_pkg::*;
#(
  parameter int RES_DEPTH = 4,
  parameter int IDLE_GAP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_c,
  input  logic [3:0]  res_flags,
  input  logic        err_valid,
  output logic        err_ready,
  input  logic [5:0]  err_flags,
  output logic [39:0] ser_in,
  output logic        ser_load,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int CNT_W = $clog2(FRAME_BITS * DATA_WORDS + IDLE_GAP);
  localparam logic [CNT_W-1:0] RES_WAIT = CNT_W'(FRAME_BITS * DATA_WORDS + IDLE_GAP - 1);
  localparam logic [CNT_W-1:0] ERR_WAIT = CNT_W'(FRAME_BITS * CTL_WORDS + IDLE_GAP - 1);

  sched_state_e     state;
  logic [CNT_W-1:0] wait_cnt;
  logic [35:0]      fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             err_full;
  logic [5:0]       err_data;
  logic             can_issue;
  logic             issue_err;
  logic             issue_res;

  mtm_alu_sync_fifo #(
    .WIDTH(36),
    .DEPTH(RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_valid && !fifo_full),
    .din   ({res_c, res_flags}),
    .pop   (issue_res),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_ready = !fifo_full;
  assign err_ready = !err_full;

  // The last WAIT cycle may issue directly, which keeps loads exactly one frame plus gap apart.
  assign can_issue = (state == ST_IDLE) || (wait_cnt == '0);
  assign issue_err = can_issue && err_full;
  assign issue_res = can_issue && !err_full && !fifo_empty;

  assign busy = (state == ST_WAIT) || !fifo_empty || err_full || ser_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_full <= 1'b0;
      err_data <= '0;
    end else if (issue_err) begin
      err_full <= 1'b0;
    end else if (err_valid && !err_full) begin
      err_full <= 1'b1;
      err_data <= err_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      ser_in      <= '0;
      ser_load    <= 1'b0;
      frames_sent <= '0;
    end else begin
      ser_load <= 1'b0;
      if (issue_err || issue_res) begin
        ser_in      <= issue_err ? error_word(err_data)
                                 : result_word(fifo_dout[35:4], fifo_dout[3:0]);
        wait_cnt    <= issue_err ? ERR_WAIT : RES_WAIT;
        ser_load    <= 1'b1;
        frames_sent <= frames_sent + 16'd1;
        state       <= ST_WAIT;
      end else if (state == ST_WAIT) begin
        if (wait_cnt == '0)
          state <= ST_IDLE;
        else
          wait_cnt <= wait_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_out_scheduler.sv
// Randomized scoreboard bench for mtm_alu_out_scheduler against a time-based
// model of queued work and the earliest cycle the serializer is free again.
module tb_mtm_alu_out_scheduler;

  localparam int RES_DEPTH = 4;
  localparam int IDLE_GAP  = 1;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_c;
  logic [3:0]  res_flags;
  logic        err_valid;
  logic        err_ready;
  logic [5:0]  err_flags;
  logic [39:0] ser_in;
  logic        ser_load;
  logic        busy;
  logic [15:0] frames_sent;

  typedef struct {
    logic [39:0] word;
    int          t;
  } exp_item_t;

  exp_item_t   sb[$];
  logic [39:0] m_res_q[$];
  bit          m_err_pend;
  logic [39:0] m_err_word;
  int          m_next_free;
  int          exp_frames;
  int          cyc;
  int          checks;
  int          errors;

  mtm_alu_out_scheduler #(
    .RES_DEPTH(RES_DEPTH),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_c      (res_c),
    .res_flags  (res_flags),
    .err_valid  (err_valid),
    .err_ready  (err_ready),
    .err_flags  (err_flags),
    .ser_in     (ser_in),
    .ser_load   (ser_load),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_res_q.delete();
    sb.delete();
    m_err_pend  = 1'b0;
    m_next_free = 0;
    exp_frames  = 0;
  endtask

  // Called at a falling edge: drives inputs, checks flow control and busy,
  // then predicts what the coming rising edge issues and accepts.
  task automatic applyStimulus(input bit rv, input logic [31:0] c, input logic [3:0] f,
                               input bit ev, input logic [5:0] ef,
                               output bit acc_r, output bit acc_e);
    int t;
    bit rdy_r;
    bit rdy_e;
    res_valid = rv;
    res_c     = c;
    res_flags = f;
    err_valid = ev;
    err_flags = ef;
    rdy_r = (m_res_q.size() < RES_DEPTH);
    rdy_e = !m_err_pend;
    checkOutput("res_ready", 64'(res_ready), 64'(rdy_r));
    checkOutput("err_ready", 64'(err_ready), 64'(rdy_e));
    checkOutput("busy", 64'(busy),
                64'((cyc < m_next_free) || (m_res_q.size() > 0) || m_err_pend));
    t = cyc + 1;
    if (t >= m_next_free) begin
      if (m_err_pend) begin
        sb.push_back('{word: m_err_word, t: t});
        m_next_free = t + 11 * 1 + IDLE_GAP;
        m_err_pend  = 1'b0;
      end else if (m_res_q.size() > 0) begin
        sb.push_back('{word: m_res_q.pop_front(), t: t});
        m_next_free = t + 11 * 5 + IDLE_GAP;
      end
    end
    acc_r = rv && rdy_r;
    acc_e = ev && rdy_e;
    if (acc_r) m_res_q.push_back({c, 1'b0, f, 3'b000});
    if (acc_e) begin
      m_err_pend = 1'b1;
      m_err_word = {32'h0, 1'b1, ef, 1'b0};
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 6'h0, a, b);
  endtask

  // Pushes a list of results back to back, holding each until it is accepted.
  task automatic push_results(input logic [31:0] cs[$], input logic [3:0] fs[$]);
    bit a, b;
    int k = 0;
    for (int n = 0; n < 1000 && k < cs.size(); n++) begin
      applyStimulus(1'b1, cs[k], fs[k], 1'b0, 6'h0, a, b);
      if (a) k++;
    end
    checkOutput("push_results_done", 64'(k), 64'(cs.size()));
  endtask

  task automatic reset_outputs_zero(input string tag);
    checkOutput({tag, "_ser_in"}, 64'(ser_in), 64'h0);
    checkOutput({tag, "_ser_load"}, 64'(ser_load), 64'h0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'h0);
    checkOutput({tag, "_frames_sent"}, 64'(frames_sent), 64'h0);
    checkOutput({tag, "_res_ready"}, 64'(res_ready), 64'h1);
    checkOutput({tag, "_err_ready"}, 64'(err_ready), 64'h1);
  endtask

  exp_item_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ser_load) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_load", 64'(ser_in), 64'h0);
          if (ser_in == 40'h0) begin
            errors++;
            $display("[TB] FAIL unexpected_load: load seen, none expected (cycle %0d)", cyc);
          end
        end else begin
          mon_e = sb.pop_front();
          checkOutput("ser_in", 64'(ser_in), 64'(mon_e.word));
          checkOutput("load_cycle", 64'(cyc), 64'(mon_e.t));
          exp_frames++;
          checkOutput("frames_sent", 64'(frames_sent), 64'(exp_frames));
        end
      end else if (sb.size() > 0 && sb[0].t <= cyc) begin
        mon_e = sb.pop_front();
        checkOutput("missed_load_cycle", 64'(cyc), 64'(mon_e.t));
      end
    end
  end

  initial begin
    bit rv, ev, acc_r, acc_e;
    logic [31:0] c;
    logic [3:0]  f;
    logic [5:0]  ef;
    logic [31:0] cs[$];
    logic [3:0]  fs[$];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    res_valid = 1'b0; res_c = '0; res_flags = '0;
    err_valid = 1'b0; err_flags = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_outputs_zero("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    $display("[TB] single result");
    applyStimulus(1'b1, 32'h12345678, 4'b0010, 1'b0, 6'h0, acc_r, acc_e);
    idle_cycles(60);

    $display("[TB] single error");
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 6'b100100, acc_r, acc_e);
    idle_cycles(15);

    $display("[TB] back-to-back results");
    cs = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    fs = '{4'h1, 4'h8, 4'hF};
    push_results(cs, fs);
    idle_cycles(180);

    $display("[TB] full FIFO");
    cs = '{32'h00000010};
    fs = '{4'h4};
    push_results(cs, fs);
    idle_cycles(3);
    cs = '{32'h00000011, 32'h00000012, 32'h00000013, 32'h00000014, 32'h00000015};
    fs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    push_results(cs, fs);
    idle_cycles(340);

    $display("[TB] error priority");
    cs = '{32'hDEAD0000, 32'hBEEF0001};
    fs = '{4'h6, 4'h9};
    push_results(cs, fs);
    idle_cycles(5);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 6'b001011, acc_r, acc_e);
    idle_cycles(140);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 32'h55AA55AA, 4'hC, 1'b0, 6'h0, acc_r, acc_e);
    applyStimulus(1'b1, 32'h0F0F0F0F, 4'h3, 1'b0, 6'h0, acc_r, acc_e);
    idle_cycles(21);
    #2 rst_n = 1'b0;
    #1 reset_outputs_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 6'b010010, acc_r, acc_e);
    idle_cycles(20);

    $display("[TB] random traffic");
    rv = 1'b0; ev = 1'b0; c = '0; f = '0; ef = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!rv && $urandom_range(0, (i < 2000) ? 40 : 2) == 0) begin
        rv = 1'b1;
        c  = $urandom;
        f  = 4'($urandom_range(0, 15));
      end
      if (!ev && $urandom_range(0, 70) == 0) begin
        ev = 1'b1;
        ef = 6'($urandom_range(0, 63));
      end
      applyStimulus(rv, c, f, ev, ef, acc_r, acc_e);
      if (acc_r) rv = 1'b0;
      if (acc_e) ev = 1'b0;
    end

    for (int n = 0; n < 600 && (m_res_q.size() > 0 || m_err_pend || cyc <= m_next_free); n++)
      idle_cycles(1);
    idle_cycles(2);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
